mac_tx_frame_arbiter: RTL and testbench

//  Packet-granular 2:1 round-robin arbiter feeding the Ethernet MAC TX FIFO AXI-Stream input.

---
 rtl/mac_arb_pkg.sv | 23 ++
 rtl/axis_out_reg.sv | 37 +++
 rtl/mac_tx_frame_arbiter.sv | 141 ++++++++++++++
 tb/tb_mac_tx_frame_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_arb_pkg.sv
// Shared types and constants for the MAC TX frame arbiter.
package mac_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT0,
        ARB_GNT1
    } arb_state_t;

    // Source indices: 0 is the RX->TX echo path, 1 is the local frame generator.
    localparam int SRC_ECHO = 0;
    localparam int SRC_GEN  = 1;

    // One-hot grant vector presented for a given arbiter state.
    function automatic logic [1:0] grant_of(arb_state_t s);
        case (s)
            ARB_GNT0: return 2'b01;
            ARB_GNT1: return 2'b10;
            default:  return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream register slice carrying {tlast, tdata}.
// Accepts a new beat whenever it is empty or its current beat leaves
// in the same cycle, so it sustains one beat per clock.
module axis_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [DATA_WIDTH:0] s_beat_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    output logic [DATA_WIDTH:0] m_beat_o,
    output logic                m_valid_o,
    input  logic                m_ready_i
);

    logic                valid_q;
    logic [DATA_WIDTH:0] beat_q;

    assign s_ready_o = !valid_q || m_ready_i;
    assign m_valid_o = valid_q;
    assign m_beat_o  = beat_q;

    // Load on upstream handshake; drop valid once the downstream takes the beat.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else if (s_valid_i && s_ready_o) begin
            valid_q <= 1'b1;
            beat_q  <= s_beat_i;
        end else if (m_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mac_tx_frame_arbiter.sv
// Packet-granular 2:1 round-robin arbiter in front of the MAC TX FIFO.
// A grant lasts from the first beat to the tlast beat, so frames never
// interleave; the IDLE cycle between frames is where the next grant is chosen.
module mac_tx_frame_arbiter
    import mac_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_trdy,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_trdy,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_trdy,
    output logic [1:0]            o_grant,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt0,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt1
);

    arb_state_t          state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                pick;
    logic [1:0]          grant;
    logic [1:0]          src_valid;
    logic [1:0]          src_last;
    logic [1:0]          src_trdy;
    logic [1:0]          frame_done;
    logic                out_ready;
    logic [DATA_WIDTH:0] in_beat;
    logic [DATA_WIDTH:0] out_beat;
    logic [CNT_WIDTH-1:0] frame_cnt [2];

    assign src_valid  = {s1_axis_tvalid, s0_axis_tvalid};
    assign src_last   = {s1_axis_tlast, s0_axis_tlast};
    assign frame_done = src_valid & src_trdy & src_last;

    // State and round-robin pointer registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= 1'(SRC_ECHO);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state: choose a source in IDLE, release the grant on the tlast handshake.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pick    = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_enable && (|src_valid)) begin
                    pick    = src_valid[ptr_q] ? ptr_q : ~ptr_q;
                    state_d = pick ? ARB_GNT1 : ARB_GNT0;
                end
            end
            ARB_GNT0: begin
                if (frame_done[SRC_ECHO]) begin
                    state_d = ARB_IDLE;
                    ptr_d   = 1'(SRC_GEN);
                end
            end
            ARB_GNT1: begin
                if (frame_done[SRC_GEN]) begin
                    state_d = ARB_IDLE;
                    ptr_d   = 1'(SRC_ECHO);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs decoded from the current state only.
    always_comb begin
        grant   = grant_of(state_q);
        o_grant = grant;
        o_busy  = (state_q != ARB_IDLE) || m_axis_tvalid;
    end

    // Per-source ready gating and frame counters.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [CNT_WIDTH-1:0] cnt_q;

            assign src_trdy[gi]   = grant[gi] & out_ready;
            assign frame_cnt[gi]  = cnt_q;

            // Count frames completed by this source; wraps at 2**CNT_WIDTH.
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    cnt_q <= '0;
                end else if (frame_done[gi]) begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    assign s0_axis_trdy = src_trdy[SRC_ECHO];
    assign s1_axis_trdy = src_trdy[SRC_GEN];
    assign o_frame_cnt0 = frame_cnt[SRC_ECHO];
    assign o_frame_cnt1 = frame_cnt[SRC_GEN];

    // Data mux follows the grant; only the granted source can be taken.
    always_comb begin
        in_beat = grant[SRC_GEN] ? {s1_axis_tlast, s1_axis_tdata}
                                 : {s0_axis_tlast, s0_axis_tdata};
    end

    axis_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .s_beat_i  (in_beat),
        .s_valid_i (|(src_valid & grant)),
        .s_ready_o (out_ready),
        .m_beat_o  (out_beat),
        .m_valid_o (m_axis_tvalid),
        .m_ready_i (m_axis_trdy)
    );

    assign m_axis_tdata = out_beat[DATA_WIDTH-1:0];
    assign m_axis_tlast = out_beat[DATA_WIDTH];

endmodule

// File: tb/tb_mac_tx_frame_arbiter.sv
// Testbench for mac_tx_frame_arbiter: frame-level round-robin reference model,
// queue-driven sources, per-beat scoreboard on the output stream.
module tb_mac_tx_frame_arbiter;

    localparam int DW   = 8;
    localparam int CW   = 16;
    localparam int CW_N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, en;
    logic [DW-1:0] s0_axis_tdata, s1_axis_tdata;
    logic          s0_axis_tvalid, s0_axis_tlast, s1_axis_tvalid, s1_axis_tlast;
    logic          s0_axis_trdy, s1_axis_trdy;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_trdy;
    logic [1:0]    o_grant;
    logic          o_busy;
    logic [CW-1:0] o_frame_cnt0, o_frame_cnt1;

    // Narrow-counter instance sharing all inputs, used to observe counter wrap.
    logic            n_s0_trdy, n_s1_trdy, n_m_tvalid, n_m_tlast, n_busy;
    logic [DW-1:0]   n_m_tdata;
    logic [1:0]      n_grant;
    logic [CW_N-1:0] n_cnt0, n_cnt1;

    mac_tx_frame_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tlast(s0_axis_tlast), .s0_axis_trdy(s0_axis_trdy),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tlast(s1_axis_tlast), .s1_axis_trdy(s1_axis_trdy),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_trdy(m_axis_trdy),
        .o_grant(o_grant), .o_busy(o_busy),
        .o_frame_cnt0(o_frame_cnt0), .o_frame_cnt1(o_frame_cnt1)
    );

    mac_tx_frame_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW_N)) dut_n (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tlast(s0_axis_tlast), .s0_axis_trdy(n_s0_trdy),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tlast(s1_axis_tlast), .s1_axis_trdy(n_s1_trdy),
        .m_axis_tdata(n_m_tdata), .m_axis_tvalid(n_m_tvalid),
        .m_axis_tlast(n_m_tlast), .m_axis_trdy(m_axis_trdy),
        .o_grant(n_grant), .o_busy(n_busy),
        .o_frame_cnt0(n_cnt0), .o_frame_cnt1(n_cnt1)
    );

    logic [8:0] q0[$], q1[$], new0[$], new1[$], exp_q[$];
    bit         pop0, pop1, trdy_rand, prev_stall, check_bubble, in_frame;
    logic       trdy_force;
    logic [8:0] prev_out;
    int         ptr_m, n_checks, n_fail, cyc, out_beats, n_hs0, n_hs1;
    int         first_hs_cyc, first_valid_cyc, last_tlast_cyc;
    int         cnt_m[2];

    // Stage one frame of len beats for a source (incrementing or random data).
    task automatic add_frame(input int src, input int len, input bit rnd, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            logic [7:0] d;
            d = rnd ? 8'($urandom) : base + 8'(i);
            if (src == 0) new0.push_back({(i == len - 1), d});
            else          new1.push_back({(i == len - 1), d});
        end
    endtask

    // Reference: frames already waiting are served in round-robin order at frame
    // granularity; the pointer moves to the source not just served.
    task automatic model_load();
        int i0, i1, p;
        i0 = 0; i1 = 0; p = ptr_m;
        while (i0 < new0.size() || i1 < new1.size()) begin
            int k;
            bit fin;
            if (p == 0) k = (i0 < new0.size()) ? 0 : 1;
            else        k = (i1 < new1.size()) ? 1 : 0;
            fin = 1'b0;
            while (!fin) begin
                if (k == 0) begin
                    exp_q.push_back(new0[i0]);
                    fin = new0[i0][8] || (i0 + 1 >= new0.size());
                    i0++;
                end else begin
                    exp_q.push_back(new1[i1]);
                    fin = new1[i1][8] || (i1 + 1 >= new1.size());
                    i1++;
                end
            end
            cnt_m[k]++;
            p = 1 - k;
        end
        ptr_m = p;
        foreach (new0[i]) q0.push_back(new0[i]);
        foreach (new1[i]) q1.push_back(new1[i]);
        new0.delete();
        new1.delete();
    endtask

    // One clock: drive after the edge, observe at the falling edge.
    task automatic step();
        bit h0, h1, bl;
        @(posedge clk);
        #1;
        cyc++;
        if (pop0) begin q0.delete(0); pop0 = 1'b0; end
        if (pop1) begin q1.delete(0); pop1 = 1'b0; end
        if (q0.size() > 0) begin
            s0_axis_tvalid = 1'b1; s0_axis_tlast = q0[0][8]; s0_axis_tdata = q0[0][7:0];
        end else begin
            s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0; s0_axis_tdata = '0;
        end
        if (q1.size() > 0) begin
            s1_axis_tvalid = 1'b1; s1_axis_tlast = q1[0][8]; s1_axis_tdata = q1[0][7:0];
        end else begin
            s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0; s1_axis_tdata = '0;
        end
        m_axis_trdy = trdy_rand ? ($urandom_range(0, 3) != 0) : trdy_force;
        @(negedge clk);
        if (prev_stall) begin
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== prev_out) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%b beat=%h required v=1 beat=%h",
                         m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, prev_out);
            end
        end
        if (m_axis_tvalid && !m_axis_trdy) begin
            n_checks++;
            if (s0_axis_trdy !== 1'b0 || s1_axis_trdy !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_trdy: got trdy=%b%b required 00", s1_axis_trdy, s0_axis_trdy);
            end
        end
        h0 = s0_axis_tvalid && s0_axis_trdy;
        h1 = s1_axis_tvalid && s1_axis_trdy;
        if (h0) begin
            pop0 = 1'b1; n_hs0++; n_checks++;
            if (o_grant !== 2'b01) begin
                n_fail++; $display("FAIL grant_s0: got %b required 01", o_grant);
            end
        end
        if (h1) begin
            pop1 = 1'b1; n_hs1++; n_checks++;
            if (o_grant !== 2'b10) begin
                n_fail++; $display("FAIL grant_s1: got %b required 10", o_grant);
            end
        end
        if (h0 || h1) begin
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            if (!in_frame && check_bubble && last_tlast_cyc >= 0) begin
                n_checks++;
                if (cyc - last_tlast_cyc != 2) begin
                    n_fail++;
                    $display("FAIL frame_gap: got %0d cycles required 2", cyc - last_tlast_cyc);
                end
            end
            bl = h0 ? s0_axis_tlast : s1_axis_tlast;
            in_frame = !bl;
            if (bl) last_tlast_cyc = cyc;
        end
        if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_axis_tvalid && m_axis_trdy) begin
            n_checks++;
            out_beats++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_beat: got %h required no beat", {m_axis_tlast, m_axis_tdata});
            end else begin
                if ({m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL out_beat: got %h required %h", {m_axis_tlast, m_axis_tdata}, exp_q[0]);
                end
                exp_q.delete(0);
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_trdy;
        prev_out   = {m_axis_tlast, m_axis_tdata};
    endtask

    task automatic drain(input int budget, input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0 || o_busy) && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d beats outstanding required 0", name, exp_q.size());
        end
        $display("%s: drained after %0d cycles, cnt0=%0d cnt1=%0d", name, k, o_frame_cnt0, o_frame_cnt1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete(); exp_q.delete(); new0.delete(); new1.delete();
        pop0 = 1'b0; pop1 = 1'b0; prev_stall = 1'b0; in_frame = 1'b0;
        s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0; s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
        ptr_m = 0; cnt_m[0] = 0; cnt_m[1] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0; m_axis_trdy = 1'b0;
        s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0; s0_axis_tdata = '0;
        s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0; s1_axis_tdata = '0;
        #1 rst_n = 1'b0;
        #11;
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin
            n_fail++; $display("FAIL reset_m_axis: got %b required 0", {m_axis_tvalid, m_axis_tlast, m_axis_tdata});
        end
        n_checks++;
        if ({s1_axis_trdy, s0_axis_trdy, o_grant, o_busy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b required 00000", {s1_axis_trdy, s0_axis_trdy, o_grant, o_busy});
        end
        n_checks++;
        if (o_frame_cnt0 !== '0 || o_frame_cnt1 !== '0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d required 0/0", o_frame_cnt0, o_frame_cnt1);
        end
        do_reset();
        en = 1'b1; trdy_force = 1'b1;
        repeat (3) step();
        n_checks++;
        if (o_grant !== 2'b00 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_req: got grant=%b busy=%b required 00/0", o_grant, o_busy);
        end
        $display("test_reset: done");
    endtask

    task automatic test_single_source();
        first_hs_cyc = -1; first_valid_cyc = -1;
        add_frame(0, 4, 1'b0, 8'h11);
        model_load();
        drain(50, "test_single_source");
        n_checks++;
        if (first_valid_cyc - first_hs_cyc != 1) begin
            n_fail++; $display("FAIL latency: got %0d required 1", first_valid_cyc - first_hs_cyc);
        end
        n_checks++;
        if (o_frame_cnt0 !== CW'(cnt_m[0]) || o_frame_cnt1 !== CW'(cnt_m[1])) begin
            n_fail++; $display("FAIL single_cnt: got %0d/%0d required %0d/%0d", o_frame_cnt0, o_frame_cnt1, cnt_m[0], cnt_m[1]);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        check_bubble = 1'b1; last_tlast_cyc = -1; trdy_force = 1'b1;
        add_frame(0, 3, 1'b0, 8'hA1);
        add_frame(0, 3, 1'b0, 8'hA4);
        add_frame(1, 3, 1'b0, 8'hB1);
        add_frame(1, 3, 1'b0, 8'hB4);
        model_load();
        drain(100, "test_round_robin");
        check_bubble = 1'b0;
        n_checks++;
        if (o_frame_cnt0 !== CW'(cnt_m[0]) || o_frame_cnt1 !== CW'(cnt_m[1])) begin
            n_fail++; $display("FAIL rr_cnt: got %0d/%0d required %0d/%0d", o_frame_cnt0, o_frame_cnt1, cnt_m[0], cnt_m[1]);
        end
    endtask

    task automatic test_backpressure();
        int base, k;
        base = out_beats; k = 0; trdy_force = 1'b1;
        add_frame(0, 6, 1'b0, 8'h31);
        model_load();
        while (out_beats < base + 2 && k < 20) begin step(); k++; end
        n_checks++;
        if (k >= 20) begin
            n_fail++; $display("FAIL bp_start: got %0d beats required 2", out_beats - base);
        end
        trdy_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || s0_axis_trdy !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold: got v=%b trdy=%b required 1/0", m_axis_tvalid, s0_axis_trdy);
            end
        end
        trdy_force = 1'b1;
        drain(50, "test_backpressure");
    endtask

    task automatic test_enable();
        int base, k;
        base = n_hs1; k = 0; trdy_force = 1'b1; en = 1'b1;
        add_frame(1, 5, 1'b0, 8'h41);
        model_load();
        while (n_hs1 < base + 2 && k < 20) begin step(); k++; end
        en = 1'b0;
        add_frame(0, 3, 1'b0, 8'h51);
        model_load();
        k = 0;
        while ((q1.size() != 0 || o_busy) && k < 30) begin step(); k++; end
        n_checks++;
        if (k >= 30 || n_hs1 != base + 5) begin
            n_fail++; $display("FAIL en_s1_complete: got %0d beats required 5", n_hs1 - base);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (o_grant !== 2'b00 || s0_axis_trdy !== 1'b0 || o_busy !== 1'b0) begin
                n_fail++; $display("FAIL en_hold_idle: got grant=%b trdy0=%b busy=%b required 00/0/0", o_grant, s0_axis_trdy, o_busy);
            end
        end
        en = 1'b1;
        step();
        n_checks++;
        if (o_grant !== 2'b01) begin
            n_fail++; $display("FAIL en_regrant: got %b required 01", o_grant);
        end
        drain(50, "test_enable");
        n_checks++;
        if (o_frame_cnt0 !== CW'(cnt_m[0]) || o_frame_cnt1 !== CW'(cnt_m[1])) begin
            n_fail++; $display("FAIL en_cnt: got %0d/%0d required %0d/%0d", o_frame_cnt0, o_frame_cnt1, cnt_m[0], cnt_m[1]);
        end
    endtask

    task automatic test_reset_midframe();
        int base, k;
        base = out_beats; k = 0; trdy_force = 1'b1;
        add_frame(0, 5, 1'b0, 8'h61);
        model_load();
        while (out_beats < base + 2 && k < 20) begin step(); k++; end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_axis_tvalid, s0_axis_trdy, s1_axis_trdy, o_grant, o_busy} !== 6'b0) begin
            n_fail++; $display("FAIL async_reset_ctl: got %b required 000000", {m_axis_tvalid, s0_axis_trdy, s1_axis_trdy, o_grant, o_busy});
        end
        n_checks++;
        if (o_frame_cnt0 !== '0 || o_frame_cnt1 !== '0) begin
            n_fail++; $display("FAIL async_reset_cnt: got %0d/%0d required 0/0", o_frame_cnt0, o_frame_cnt1);
        end
        do_reset();
        add_frame(0, 3, 1'b0, 8'h71);
        add_frame(1, 3, 1'b0, 8'h81);
        model_load();
        step();
        step();
        n_checks++;
        if (o_grant !== 2'b01) begin
            n_fail++; $display("FAIL restart_s0: got %b required 01", o_grant);
        end
        drain(60, "test_reset_midframe");
    endtask

    task automatic test_random();
        trdy_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int f = 0; f < 4; f++) begin
                if ($urandom_range(0, 3) != 0) add_frame(0, $urandom_range(1, 6), 1'b1, 8'h00);
                if ($urandom_range(0, 3) != 0) add_frame(1, $urandom_range(1, 6), 1'b1, 8'h00);
            end
            model_load();
            drain(800, "test_random");
            n_checks++;
            if (o_frame_cnt0 !== CW'(cnt_m[0]) || o_frame_cnt1 !== CW'(cnt_m[1])) begin
                n_fail++; $display("FAIL rand_cnt: got %0d/%0d required %0d/%0d", o_frame_cnt0, o_frame_cnt1, cnt_m[0], cnt_m[1]);
            end
        end
        trdy_rand = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        trdy_force = 1'b1;
        for (int i = 0; i < 17; i++) add_frame(0, 1, 1'b1, 8'h00);
        model_load();
        drain(200, "test_wrap");
        n_checks++;
        if (n_cnt0 !== CW_N'(cnt_m[0]) || n_cnt1 !== CW_N'(cnt_m[1])) begin
            n_fail++; $display("FAIL wrap_narrow: got %0d/%0d required %0d/%0d", n_cnt0, n_cnt1, cnt_m[0] % 16, cnt_m[1] % 16);
        end
        n_checks++;
        if (o_frame_cnt0 !== CW'(cnt_m[0]) || o_frame_cnt1 !== CW'(cnt_m[1])) begin
            n_fail++; $display("FAIL wrap_wide: got %0d/%0d required %0d/%0d", o_frame_cnt0, o_frame_cnt1, cnt_m[0], cnt_m[1]);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; out_beats = 0; n_hs0 = 0; n_hs1 = 0;
        trdy_rand = 1'b0; trdy_force = 1'b1; check_bubble = 1'b0; last_tlast_cyc = -1;
        first_hs_cyc = -1; first_valid_cyc = -1;
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_enable();
        test_reset_midframe();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
